// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared definitions for the instruction fetch unit.
//   - datapath widths (CPU_WIDTH, PC_WIDTH)
//   - well-known instruction encodings (INST_NOP, INST_EBREAK)
//   - fetch FSM state type and the FIFO entry type
package ifu_fetch_pkg;

  localparam int unsigned CPU_WIDTH  = 64;
  localparam int unsigned PC_WIDTH   = 64;
  localparam int unsigned INST_WIDTH = 32;

  localparam logic [INST_WIDTH-1:0] INST_NOP    = 32'h0000_0013;
  localparam logic [INST_WIDTH-1:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
    return {pc[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// ifu_fifo: synchronous FIFO of {pc, inst} fetch entries.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           empties the FIFO; overrides same-cycle push/pop
//   push, push_data write an entry (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   head            current head entry (undefined when empty)
//   count           number of valid entries (0..DEPTH)
//   full, empty     status flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module ifu_fifo
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit feeding the decoder's inst interface.
// Issues word-aligned requests (one in flight at most), buffers returned
// words with their PC in ifu_fifo, and applies execute redirects.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   imem_req_valid/ready/addr     request channel to instruction memory
//   imem_rsp_valid/data           in-order, valid-only response channel
//   redirect_valid/pc             taken branch/jump from execute
//   inst_valid/ready, inst, inst_pc  head of the buffer towards decode
//   misalign                      one-cycle pulse for a redirect target with pc[1:0]!=0
//   halted                        fetch stopped on ebreak
// Build option: IFU_EBREAK_HALT_EN -- when defined, a fetched ebreak halts
// further requests until the next redirect; otherwise halted is tied 0.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [63:0] PC_RESET   = 64'h0000_0000_8000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        misalign,
  output logic        halted
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e   state;
  ifu_state_e   state_nxt;
  logic [63:0]  fetch_pc;
  logic [63:0]  fetch_pc_nxt;
  logic         outstanding;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] used;
  logic         credit;
  logic         req_fire;
  logic         push;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic         halt_q;
  logic         misalign_q;
  fetch_entry_t head;
  fetch_entry_t push_entry;

  // Any state other than S_REQ has exactly one response still owed.
  assign outstanding = (state != S_REQ);
  assign used        = fifo_count + {{(CW-1){1'b0}}, outstanding};
  assign credit      = (used < CW'(FIFO_DEPTH));

  // Gated by rst_n so the request stays low while reset is asserted.
  assign imem_req_valid = rst_n && (state == S_REQ) && credit && !halt_q;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // fetch_pc already points past the outstanding word while in S_WAIT.
  assign push       = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign push_entry = '{pc: fetch_pc - 64'd4, inst: imem_rsp_data};

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    case (state)
      S_REQ: begin
        if (redirect_valid) begin
          state_nxt = req_fire ? S_DROP : S_REQ;
        end else if (req_fire) begin
          state_nxt    = S_WAIT;
          fetch_pc_nxt = fetch_pc + 64'd4;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt = S_REQ;
        end else if (redirect_valid) begin
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
    if (redirect_valid) begin
      fetch_pc_nxt = align_pc(redirect_pc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_REQ;
      fetch_pc   <= PC_RESET;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

`ifdef IFU_EBREAK_HALT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
    end else if (redirect_valid) begin
      halt_q <= 1'b0;
    end else if (push && (imem_rsp_data == INST_EBREAK)) begin
      halt_q <= 1'b1;
    end
  end
`else
  assign halt_q = 1'b0;
`endif

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign inst_valid = !fifo_empty;
  assign inst       = fifo_empty ? INST_NOP : head.inst;
  assign inst_pc    = fifo_empty ? '0 : head.pc;
  assign misalign   = misalign_q;
  assign halted     = halt_q;

  // The credit rule must keep every accepted response within the buffer.
  assert property (@(posedge clk) disable iff (!rst_n) push |-> !fifo_full);

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBRK   = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        misalign;
  logic        halted;

  always #5 clk = ~clk;

  ifu_fetch #(
    .PC_RESET   (RST_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .misalign       (misalign),
    .halted         (halted)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          hs_cnt = 0;
  int          pop_cnt = 0;
  int          first_hs = -1;
  int          first_val = -1;
  int          rsp_delay = 1;
  bit          ebreak_mode = 1'b0;
  logic [63:0] exp_req_pc = RST_PC;
  logic [63:0] last_pop_pc = '0;
  logic [31:0] last_pop_data = '0;
  bit          pend = 1'b0;
  bit          pend_stale = 1'b0;
  logic [63:0] pend_addr = '0;
  int          pend_cnt = 0;

  function automatic logic [31:0] memfn(input logic [63:0] a);
    if (ebreak_mode && a == 64'h0000_0000_8000_0008) return EBRK;
    return a[31:0] ^ 32'h5A5A_0003;
  endfunction

  // Memory responder plus decoder-side scoreboard.
  task automatic model_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        exp_req_pc = RST_PC;
        pend = 1'b0;
        hs_cnt = 0;
        pop_cnt = 0;
        first_hs = -1;
        first_val = -1;
      end else begin
        if (redirect_valid) exp_q.delete();
        if (imem_rsp_valid) begin
          if (!pend_stale && !redirect_valid) exp_q.push_back('{pc: pend_addr, data: memfn(pend_addr)});
          pend = 1'b0;
        end else if (redirect_valid && pend) begin
          pend_stale = 1'b1;
        end
        if (imem_req_valid && imem_req_ready) begin
          checks++;
          if (pend) begin
            errors++;
            $display("FAIL req_overlap: request at %h while one outstanding, required none", imem_req_addr);
          end
          checks++;
          if (imem_req_addr !== exp_req_pc) begin
            errors++;
            $display("FAIL req_addr: got %h required %h", imem_req_addr, exp_req_pc);
          end
          pend = 1'b1;
          pend_addr = imem_req_addr;
          pend_cnt = rsp_delay;
          pend_stale = redirect_valid;
          exp_req_pc = exp_req_pc + 64'd4;
          hs_cnt++;
          if (first_hs < 0) first_hs = cyc;
        end
        if (redirect_valid) exp_req_pc = {redirect_pc[63:2], 2'b00};
        if (inst_valid && first_val < 0) first_val = cyc;
        if (inst_valid && inst_ready && !redirect_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL inst_unexpected: got pc %h inst %h, required no instruction", inst_pc, inst);
          end else begin
            e = exp_q.pop_front();
            if (inst_pc !== e.pc || inst !== e.data) begin
              errors++;
              $display("FAIL inst_stream: got pc %h inst %h required pc %h inst %h", inst_pc, inst, e.pc, e.data);
            end
          end
          last_pop_pc = inst_pc;
          last_pop_data = inst;
          pop_cnt++;
        end
        if (!inst_valid) begin
          checks++;
          if (inst !== NOP || inst_pc !== 64'h0) begin
            errors++;
            $display("FAIL empty_head: got inst %h pc %h required %h 0", inst, inst_pc, NOP);
          end
        end
      end
      @(posedge clk);
      #1;
      if (!rst_n || !pend) begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'hDEAD_BEEF;
      end else if (pend_cnt > 1) begin
        pend_cnt--;
        imem_rsp_valid = 1'b0;
      end else begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = memfn(pend_addr);
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    rsp_delay = 1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_pops(input int n, input int budget, input string name);
    int target = pop_cnt + n;
    for (int i = 0; i < budget && pop_cnt < target; i++) @(posedge clk);
    #2;
    checks++;
    if (pop_cnt < target) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pops required %0d", name, pop_cnt, target);
    end
  endtask

  task automatic do_redirect(input logic [63:0] t);
    redirect_pc = t;
    redirect_valid = 1'b1;
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst_inst", {32'h0, inst}, {32'h0, NOP});
    chk("rst_inst_pc", inst_pc, 64'h0);
    chk("rst_misalign", {63'h0, misalign}, 64'h0);
    chk("rst_halted", {63'h0, halted}, 64'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("rel_req_addr", imem_req_addr, RST_PC);
  endtask

  task automatic test_stream();
    int p0;
    inst_ready = 1'b1;
    apply_reset();
    wait_pops(8, 100, "stream");
    chk("first_latency", 64'(first_val - first_hs), 64'd2);
    chk("stream_last_pc", last_pop_pc, 64'h0000_0000_8000_001C);
    p0 = pop_cnt;
    repeat (20) @(posedge clk);
    chk("throughput", 64'(pop_cnt - p0), 64'd10);
  endtask

  task automatic test_backpressure();
    inst_ready = 1'b0;
    apply_reset();
    repeat (12) @(posedge clk);
    #2;
    chk("bp_requests", 64'(hs_cnt), 64'd2);
    @(negedge clk);
    chk("bp_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("bp_inst_valid", {63'h0, inst_valid}, 64'h1);
    @(posedge clk);
    #2;
    inst_ready = 1'b1;
    wait_pops(6, 60, "bp_drain");
    chk("bp_last_pc", last_pop_pc, 64'h0000_0000_8000_0014);
  endtask

  task automatic test_redirect_wait();
    int i;
    inst_ready = 1'b0;
    apply_reset();
    rsp_delay = 3;
    for (i = 0; i < 40 && hs_cnt < 2; i++) begin
      @(posedge clk);
      #2;
    end
    chk("rw_reach_wait", {63'h0, hs_cnt >= 2}, 64'h1);
    do_redirect(64'h0000_0000_8000_0100);
    @(negedge clk);
    chk("rw_flushed", {63'h0, inst_valid}, 64'h0);
    chk("rw_drop_no_req", {63'h0, imem_req_valid}, 64'h0);
    @(posedge clk);
    #2;
    rsp_delay = 1;
    inst_ready = 1'b1;
    wait_pops(1, 40, "rw");
    chk("rw_first_pc", last_pop_pc, 64'h0000_0000_8000_0100);
    wait_pops(3, 40, "rw_more");
  endtask

  task automatic test_redirect_same_rsp();
    int i;
    inst_ready = 1'b1;
    apply_reset();
    rsp_delay = 2;
    for (i = 0; i < 40 && !imem_rsp_valid; i++) begin
      @(posedge clk);
      #2;
    end
    chk("rr_found_rsp", {63'h0, imem_rsp_valid}, 64'h1);
    do_redirect(64'h0000_0000_8000_0300);
    @(negedge clk);
    chk("rr_no_push", {63'h0, inst_valid}, 64'h0);
    chk("rr_no_misalign", {63'h0, misalign}, 64'h0);
    wait_pops(1, 40, "rr");
    chk("rr_first_pc", last_pop_pc, 64'h0000_0000_8000_0300);
  endtask

  task automatic test_redirect_same_hs();
    int i;
    inst_ready = 1'b1;
    apply_reset();
    rsp_delay = 2;
    for (i = 0; i < 40 && !(imem_req_valid && imem_req_ready); i++) begin
      @(posedge clk);
      #2;
    end
    do_redirect(64'h0000_0000_8000_0400);
    @(negedge clk);
    chk("rh_drop_no_req", {63'h0, imem_req_valid}, 64'h0);
    wait_pops(1, 40, "rh");
    chk("rh_first_pc", last_pop_pc, 64'h0000_0000_8000_0400);
  endtask

  task automatic test_misalign();
    inst_ready = 1'b1;
    apply_reset();
    wait_pops(2, 40, "ma_pre");
    @(posedge clk);
    #2;
    redirect_pc = 64'h0000_0000_8000_0102;
    redirect_valid = 1'b1;
    @(negedge clk);
    chk("ma_before", {63'h0, misalign}, 64'h0);
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("ma_pulse", {63'h0, misalign}, 64'h1);
    @(negedge clk);
    chk("ma_after", {63'h0, misalign}, 64'h0);
    wait_pops(1, 40, "ma");
    chk("ma_first_pc", last_pop_pc, 64'h0000_0000_8000_0100);
  endtask

  task automatic test_ebreak();
    inst_ready = 1'b1;
    ebreak_mode = 1'b1;
    apply_reset();
`ifdef IFU_EBREAK_HALT_EN
    for (int i = 0; i < 40 && !halted; i++) @(negedge clk);
    chk("eb_halted", {63'h0, halted}, 64'h1);
    repeat (10) @(posedge clk);
    #2;
    chk("eb_no_more_req", 64'(hs_cnt), 64'd3);
    chk("eb_delivered_pc", last_pop_pc, 64'h0000_0000_8000_0008);
    chk("eb_delivered_inst", {32'h0, last_pop_data}, {32'h0, EBRK});
    @(negedge clk);
    chk("eb_req_low", {63'h0, imem_req_valid}, 64'h0);
    @(posedge clk);
    #2;
    do_redirect(64'h0000_0000_8000_0200);
    @(negedge clk);
    chk("eb_resume_halted", {63'h0, halted}, 64'h0);
    wait_pops(2, 40, "eb_resume");
    chk("eb_resume_pc", last_pop_pc, 64'h0000_0000_8000_0204);
`else
    wait_pops(5, 60, "eb_plain");
    chk("eb_plain_halted", {63'h0, halted}, 64'h0);
    chk("eb_plain_pc", last_pop_pc, 64'h0000_0000_8000_0010);
`endif
    ebreak_mode = 1'b0;
  endtask

  initial begin
    fork
      model_loop();
    join_none
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_same_rsp();
    test_redirect_same_hs();
    test_misalign();
    test_ebreak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit that produces the `inst` stream consumed by the ctrl decoder. It is the producer end of the decoder's instruction interface.
- Issues word-aligned requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned words with their PC in a small FIFO and presents them to decode with a valid/ready handshake.
- Applies branch/jump redirects from execute, discarding stale fetches.

Parameters:
- PC_RESET, 64'h0000_0000_8000_0000, PC of the first fetch after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  64  fetch address, bits [1:0] always 0.
- imem_rsp_valid  input  1  response word valid; exactly one response per accepted request, in order, ≥1 cycle after acceptance.
- imem_rsp_data  input  32  response instruction word.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  64  redirect target.
- inst_valid  output  1  FIFO head valid.
- inst_ready  input  1  decoder consumes head.
- inst  output  32  head instruction; 32'h0000_0013 (NOP) when FIFO empty.
- inst_pc  output  64  head PC; 0 when empty.
- misalign  output  1  one-cycle pulse when redirect_pc[1:0] != 0.
- halted  output  1  fetch stopped on ebreak (optional feature).

Behaviour:
- Reset (async assert, sync release): state=S_REQ, fetch_pc=PC_RESET, FIFO empty, imem_req_valid=0, inst_valid=0, inst=NOP, inst_pc=0, misalign=0, halted=0.
- imem_req_valid is combinational from state/credit, so it may rise in the first clk after rst_n deasserts.
- Credit rule: a request may issue only when fifo_count + outstanding < FIFO_DEPTH, where outstanding ∈ {0,1}. At most one request is in flight.
- States:
  - S_REQ: imem_req_valid = credit available. imem_req_addr=fetch_pc, held stable until handshake. On valid&ready → S_WAIT, fetch_pc += 4.
  - S_WAIT: on imem_rsp_valid, push {fetch_pc-4, data} into the FIFO → S_REQ.
  - S_DROP: on imem_rsp_valid, discard the data → S_REQ.
- Redirect has top priority. On redirect_valid:
  - FIFO flushed; any same-cycle pop or push is ignored.
  - fetch_pc = {redirect_pc[63:2], 2'b00}.
  - misalign pulses if redirect_pc[1:0] != 0.
  - Next state:
    - From S_REQ without handshake: S_REQ.
    - From S_REQ with handshake the same cycle: S_DROP.
    - From S_WAIT with no response: S_DROP.
    - From S_WAIT with a response the same cycle: S_REQ (response dropped).
    - From S_DROP with no response: stays S_DROP (pc updated).
    - From S_DROP with a response the same cycle: S_REQ.
- FIFO:
  - Push and pop in the same cycle allowed when not full/empty; count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow is impossible by the credit rule; an assertion checks it.
- Latency: request accept at cycle N, response at N+1 → inst_valid at N+2. Sustained throughput with a 1-cycle memory: one instruction per 2 cycles; FIFO_DEPTH does not change this (single outstanding request).
- PC arithmetic is 64-bit unsigned and wraps silently at 2^64.

Optional Feature:
- IFU_EBREAK_HALT_EN defined:
  - When a pushed word equals 32'h0010_0073, set halted=1 the next cycle and stop issuing requests.
  - The FIFO still drains.
  - A redirect clears halted and resumes fetch.
- Undefined: halted tied 0; ebreak is fetched like any other word.

Decomposition:
- Shared defines header (rvseed_defines.v) holds:
  - CPU_WIDTH and PC width.
  - INST_NOP = 32'h0000_0013 and INST_EBREAK = 32'h0010_0073.
  - IFU state encodings S_REQ/S_WAIT/S_DROP.
- Sub-module ifu_fifo: parameterised synchronous FIFO of {pc, inst} with flush, push, pop, count, full, empty.

Test Plan:
- Reset release, memory always ready, 1-cycle response, inst_ready=1:
  - imem_req_addr sequence 0x8000_0000, 0x8000_0004, ….
  - inst_pc matches each address, first inst_valid 2 cycles after the first accept.
- inst_ready=0 for 10 cycles:
  - FIFO fills to 2, imem_req_valid drops.
  - On release, order is preserved with no loss or duplicates.
- Redirect to 0x8000_0100 while in S_WAIT, response arriving 3 cycles later:
  - That response is dropped, next request addr is 0x8000_0100, FIFO is flushed.
- Redirect in the same cycle as rsp_valid, and in the same cycle as the request handshake:
  - Same-cycle rsp_valid: no stale push, next request addr = target.
  - Same-cycle request handshake: state enters S_DROP and the next response is discarded.
- Redirect to 0x8000_0102: fetch from 0x8000_0100, misalign pulses for exactly 1 cycle.
- IFU_EBREAK_HALT_EN defined, memory returns 0x0010_0073 at 0x8000_0008:
  - halted=1, no further requests, ebreak delivered to decode.
  - A redirect resumes fetch.
